// File: rtl/alu_pkg.sv
// Shared decode constants, op/state enums and the opcode/func decoder for alu_mc.
// ALU_MUL_EN adds the MUL state and the RV32M multiply decode.
package alu_pkg;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] FUNC7_BASE    = 7'b0000000;
  localparam logic [6:0] FUNC7_ALT     = 7'b0100000;
  localparam logic [6:0] FUNC7_MULDIV  = 7'b0000001;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_ILLEGAL
  } alu_op_e;

`ifdef ALU_MUL_EN
  typedef enum logic [1:0] {IDLE, MUL, DONE} alu_state_e;
`else
  typedef enum logic {IDLE, DONE} alu_state_e;
`endif

  function automatic alu_op_e alu_decode(input logic [6:0] opcode,
                                         input logic [2:0] f3,
                                         input logic [6:0] f7);
    logic    is_r, f7b, f7a;
    alu_op_e op;
    is_r = (opcode == OPCODE_OP);
    f7b  = (f7 == FUNC7_BASE);
    f7a  = (f7 == FUNC7_ALT);
    op   = ALU_ILLEGAL;
    if (is_r || opcode == OPCODE_OP_IMM) begin
      // I-type non-shift ops ignore func7 (it is part of the immediate)
      case (f3)
        3'b000: if (!is_r || f7b) op = ALU_ADD;  else if (f7a) op = ALU_SUB;
        3'b001: if (f7b)          op = ALU_SLL;
        3'b010: if (!is_r || f7b) op = ALU_SLT;
        3'b011: if (!is_r || f7b) op = ALU_SLTU;
        3'b100: if (!is_r || f7b) op = ALU_XOR;
        3'b101: if (f7b)          op = ALU_SRL;  else if (f7a) op = ALU_SRA;
        3'b110: if (!is_r || f7b) op = ALU_OR;
        default: if (!is_r || f7b) op = ALU_AND;
      endcase
`ifdef ALU_MUL_EN
      if (is_r && f7 == FUNC7_MULDIV) begin
        case (f3)
          3'b000:  op = ALU_MUL;
          3'b001:  op = ALU_MULH;
          3'b010:  op = ALU_MULHSU;
          3'b011:  op = ALU_MULHU;
          default: op = ALU_ILLEGAL;
        endcase
      end
`endif
    end
    return op;
  endfunction

endpackage

// File: rtl/alu_mc_if.sv
// Request/result handshake bundle between decode, alu_mc and writeback.
interface alu_mc_if #(parameter int REGISTER_SIZE = 32);
  logic                     valid_i;
  logic                     ready_o;
  logic [REGISTER_SIZE-1:0] data1_i;
  logic [REGISTER_SIZE-1:0] data2_i;
  logic [6:0]               opcode_i;
  logic [2:0]               func3_i;
  logic [6:0]               func7_i;
  logic                     valid_o;
  logic                     ready_i;
  logic [REGISTER_SIZE-1:0] result_o;
  logic                     illegal_o;

  modport slave (
    input  valid_i, data1_i, data2_i, opcode_i, func3_i, func7_i, ready_i,
    output ready_o, valid_o, result_o, illegal_o
  );

  modport master (
    output valid_i, data1_i, data2_i, opcode_i, func3_i, func7_i, ready_i,
    input  ready_o, valid_o, result_o, illegal_o
  );
endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier, one partial product per cycle over W cycles.
// Compiled only when ALU_MUL_EN is defined.
`ifdef ALU_MUL_EN
module alu_mul_iter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         i_start,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_a_signed,
  input  logic         i_b_signed,
  input  logic         i_hi,
  output logic         o_done,
  output logic [W-1:0] o_result
);
  localparam int CW = $clog2(W);

  logic           r_busy, r_neg, r_hi;
  logic [CW-1:0]  r_cnt;
  logic [2*W-1:0] r_mcand, r_acc;
  logic [W-1:0]   r_mplier;
  logic           w_a_neg, w_b_neg;
  logic [W-1:0]   w_mag_a, w_mag_b;
  logic [2*W-1:0] w_acc_nxt, w_prod;

  assign w_a_neg = i_a_signed & i_a[W-1];
  assign w_b_neg = i_b_signed & i_b[W-1];
  assign w_mag_a = w_a_neg ? -i_a : i_a;
  assign w_mag_b = w_b_neg ? -i_b : i_b;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_busy   <= 1'b0;
      r_neg    <= 1'b0;
      r_hi     <= 1'b0;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
    end else if (i_start) begin
      r_busy   <= 1'b1;
      r_neg    <= w_a_neg ^ w_b_neg;
      r_hi     <= i_hi;
      r_cnt    <= CW'(W - 1);
      r_mcand  <= {{W{1'b0}}, w_mag_a};
      r_acc    <= '0;
      r_mplier <= w_mag_b;
    end else if (r_busy) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - 1'b1;
      if (r_cnt == '0) r_busy <= 1'b0;
    end
  end

  // The last step's sum is sign-fixed combinationally so the caller can latch it on done
  assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_prod    = r_neg ? -w_acc_nxt : w_acc_nxt;
  assign o_result  = r_hi ? w_prod[2*W-1:W] : w_prod[W-1:0];
  assign o_done    = r_busy && (r_cnt == '0);
endmodule
`endif

// File: rtl/alu_mc.sv
// Multi-cycle RV32I ALU with registered result over valid/ready.
// ALU_MUL_EN adds MUL/MULH/MULHSU/MULHU via alu_mul_iter.
module alu_mc #(
  parameter int REGISTER_SIZE = 32
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  alu_mc_if.slave bus
);
  import alu_pkg::*;

  localparam int SH = $clog2(REGISTER_SIZE);
  typedef logic [REGISTER_SIZE-1:0] word_t;

  alu_state_e    r_state, w_state_nxt;
  alu_op_e       w_op;
  word_t         w_alu_res, r_result;
  logic          r_illegal;
  logic          w_ready, w_acc, w_is_mul;
  logic [SH-1:0] w_shamt;

  assign w_op    = alu_decode(bus.opcode_i, bus.func3_i, bus.func7_i);
  assign w_shamt = bus.data2_i[SH-1:0];

  always_comb begin
    w_alu_res = '0;
    case (w_op)
      ALU_ADD:  w_alu_res = bus.data1_i + bus.data2_i;
      ALU_SUB:  w_alu_res = bus.data1_i - bus.data2_i;
      ALU_SLL:  w_alu_res = bus.data1_i << w_shamt;
      ALU_SLT:  w_alu_res[0] = $signed(bus.data1_i) < $signed(bus.data2_i);
      ALU_SLTU: w_alu_res[0] = bus.data1_i < bus.data2_i;
      ALU_XOR:  w_alu_res = bus.data1_i ^ bus.data2_i;
      ALU_SRL:  w_alu_res = bus.data1_i >> w_shamt;
      ALU_SRA:  w_alu_res = word_t'($signed(bus.data1_i) >>> w_shamt);
      ALU_OR:   w_alu_res = bus.data1_i | bus.data2_i;
      ALU_AND:  w_alu_res = bus.data1_i & bus.data2_i;
      default:  w_alu_res = '0;
    endcase
  end

`ifdef ALU_MUL_EN
  logic  w_mul_done;
  word_t w_mul_result;

  assign w_is_mul = w_op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};

  alu_mul_iter #(.W(REGISTER_SIZE)) u_mul (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .i_start    (w_acc && w_is_mul),
    .i_a        (bus.data1_i),
    .i_b        (bus.data2_i),
    .i_a_signed (w_op inside {ALU_MUL, ALU_MULH, ALU_MULHSU}),
    .i_b_signed (w_op inside {ALU_MUL, ALU_MULH}),
    .i_hi       (w_op != ALU_MUL),
    .o_done     (w_mul_done),
    .o_result   (w_mul_result)
  );
`else
  assign w_is_mul = 1'b0;
`endif

  // ready_i reaches ready_o only while a result is held
  assign w_ready = (r_state == IDLE) ? rst_ni : ((r_state == DONE) && bus.ready_i);
  assign w_acc   = bus.valid_i && w_ready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_acc) w_state_nxt = DONE;
      DONE: if (bus.ready_i) w_state_nxt = bus.valid_i ? DONE : IDLE;
`ifdef ALU_MUL_EN
      MUL:  if (w_mul_done) w_state_nxt = DONE;
`endif
      default: w_state_nxt = IDLE;
    endcase
`ifdef ALU_MUL_EN
    if (w_acc && w_is_mul) w_state_nxt = MUL;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_result  <= '0;
      r_illegal <= 1'b0;
    end else if (w_acc && !w_is_mul) begin
      r_result  <= w_alu_res;
      r_illegal <= (w_op == ALU_ILLEGAL);
    end
`ifdef ALU_MUL_EN
    else if (w_acc) begin
      r_illegal <= 1'b0;
    end else if (w_mul_done) begin
      r_result  <= w_mul_result;
    end
`endif
  end

  assign bus.ready_o   = w_ready;
  assign bus.valid_o   = (r_state == DONE);
  assign bus.result_o  = r_result;
  assign bus.illegal_o = r_illegal;
endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc; multiply steps run when ALU_MUL_EN is defined.
module tb_alu_mc;
  import alu_pkg::*;

  localparam logic [6:0] R = OPCODE_OP;
  localparam logic [6:0] I = OPCODE_OP_IMM;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  alu_mc_if #(.REGISTER_SIZE(32)) bus ();

  alu_mc #(.REGISTER_SIZE(32)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] a, input logic [31:0] b);
    bus.opcode_i = op;
    bus.func3_i  = f3;
    bus.func7_i  = f7;
    bus.data1_i  = a;
    bus.data2_i  = b;
    bus.valid_i  = 1'b1;
  endtask

  // Issue one op from an idle/draining state and check the result one cycle after accept
  task automatic do_op(input string tag, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input logic ill);
    @(posedge clk); #1;
    drive(op, f3, f7, a, b);
    bus.ready_i = 1'b1;
    @(negedge clk);
    chk({tag, ".ready"}, 32'(bus.ready_o), 32'd1);
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    @(negedge clk);
    chk({tag, ".valid"}, 32'(bus.valid_o), 32'd1);
    chk({tag, ".result"}, bus.result_o, exp);
    chk({tag, ".illegal"}, 32'(bus.illegal_o), 32'(ill));
  endtask

`ifdef ALU_MUL_EN
  // Accept in cycle N, expect valid_o low through N+32 and high in N+33
  task automatic do_mul(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    @(posedge clk); #1;
    drive(R, f3, FUNC7_MULDIV, a, b);
    bus.ready_i = 1'b1;
    @(negedge clk);
    chk({tag, ".ready"}, 32'(bus.ready_o), 32'd1);
    @(posedge clk); #1;
    drive(R, 3'b000, FUNC7_BASE, 32'd99, 32'd1);
    for (int c = 1; c <= 33; c++) begin
      @(negedge clk);
      if (c == 1)  chk({tag, ".busy_ready"}, 32'(bus.ready_o), 32'd0);
      if (c == 32) chk({tag, ".early_valid"}, 32'(bus.valid_o), 32'd0);
      if (c < 33) @(posedge clk);
    end
    bus.valid_i = 1'b0;
    chk({tag, ".valid"}, 32'(bus.valid_o), 32'd1);
    chk({tag, ".result"}, bus.result_o, exp);
    chk({tag, ".illegal"}, 32'(bus.illegal_o), 32'd0);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.valid_i = 1'b0; bus.ready_i = 1'b1;
    bus.data1_i = '0; bus.data2_i = '0;
    bus.opcode_i = '0; bus.func3_i = '0; bus.func7_i = '0;

    repeat (2) @(negedge clk);
    chk("rst.ready", 32'(bus.ready_o), 32'd0);
    chk("rst.valid", 32'(bus.valid_o), 32'd0);
    chk("rst.result", bus.result_o, 32'd0);
    chk("rst.illegal", 32'(bus.illegal_o), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("post_rst.ready", 32'(bus.ready_o), 32'd1);

    do_op("add",     R, 3'b000, FUNC7_BASE, 32'd5, 32'd7, 32'd12, 1'b0);
    do_op("add_wrap",R, 3'b000, FUNC7_BASE, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0);
    do_op("sub",     R, 3'b000, FUNC7_ALT,  32'd3, 32'd5, 32'hFFFFFFFE, 1'b0);
    do_op("slt",     R, 3'b010, FUNC7_BASE, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0);
    do_op("sltu",    R, 3'b011, FUNC7_BASE, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0);
    do_op("srai",    I, 3'b101, FUNC7_ALT,  32'h80000000, 32'h00000404, 32'hF8000000, 1'b0);
    do_op("srli",    I, 3'b101, FUNC7_BASE, 32'h80000000, 32'd4, 32'h08000000, 1'b0);
    do_op("sra31",   R, 3'b101, FUNC7_ALT,  32'h80000000, 32'd31, 32'hFFFFFFFF, 1'b0);
    do_op("srl31",   R, 3'b101, FUNC7_BASE, 32'h80000000, 32'd31, 32'd1, 1'b0);
    do_op("sll_amt", R, 3'b001, FUNC7_BASE, 32'd1, 32'd36, 32'd16, 1'b0);
    do_op("addi_f7", I, 3'b000, FUNC7_ALT,  32'd10, 32'h405, 32'h40F, 1'b0);
    do_op("xor",     R, 3'b100, FUNC7_BASE, 32'h0000F0F0, 32'h0000FF00, 32'h00000FF0, 1'b0);
    do_op("or",      R, 3'b110, FUNC7_BASE, 32'h0000F0F0, 32'h00000F0F, 32'h0000FFFF, 1'b0);
    do_op("andi",    I, 3'b111, FUNC7_ALT,  32'hFF00FF00, 32'h00000FF0, 32'h00000F00, 1'b0);
    do_op("bad_opc", 7'b1111111, 3'b000, FUNC7_BASE, 32'd5, 32'd7, 32'd0, 1'b1);
    do_op("sll_alt", R, 3'b001, FUNC7_ALT,  32'd1, 32'd1, 32'd0, 1'b1);
    do_op("slli_bad",I, 3'b001, FUNC7_MULDIV, 32'd1, 32'd1, 32'd0, 1'b1);
    do_op("srl_bad", R, 3'b101, 7'b0000011, 32'd8, 32'd1, 32'd0, 1'b1);
    do_op("md_f3_4", R, 3'b100, FUNC7_MULDIV, 32'd3, 32'd3, 32'd0, 1'b1);
`ifndef ALU_MUL_EN
    do_op("mul_off", R, 3'b000, FUNC7_MULDIV, 32'd3, 32'd3, 32'd0, 1'b1);
`endif

    // Back-to-back: one result per cycle
    @(posedge clk); #1;
    bus.ready_i = 1'b1;
    drive(R, 3'b000, FUNC7_BASE, 32'd100, 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("b2b%0d.ready", i), 32'(bus.ready_o), 32'd1);
      if (i > 0) begin
        chk($sformatf("b2b%0d.valid", i - 1), 32'(bus.valid_o), 32'd1);
        chk($sformatf("b2b%0d.result", i - 1), bus.result_o, 32'(99 + i));
      end
      @(posedge clk); #1;
      if (i < 7) drive(R, 3'b000, FUNC7_BASE, 32'd100, 32'(i + 1));
      else       bus.valid_i = 1'b0;
    end
    @(negedge clk);
    chk("b2b7.valid", 32'(bus.valid_o), 32'd1);
    chk("b2b7.result", bus.result_o, 32'd107);

    // Back-pressure: result held, new op not taken
    @(posedge clk); #1;
    drive(R, 3'b000, FUNC7_BASE, 32'd20, 32'd22);
    @(posedge clk); #1;
    bus.ready_i = 1'b0;
    drive(R, 3'b000, FUNC7_BASE, 32'd1, 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("stall%0d.valid", k), 32'(bus.valid_o), 32'd1);
      chk($sformatf("stall%0d.result", k), bus.result_o, 32'd42);
      chk($sformatf("stall%0d.ready", k), 32'(bus.ready_o), 32'd0);
      if (k < 2) @(posedge clk);
    end
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    #1;
    chk("stall_rel.ready", 32'(bus.ready_o), 32'd1);
    @(negedge clk);
    chk("drain.valid", 32'(bus.valid_o), 32'd0);

    // Reset while a result is held
    @(posedge clk); #1;
    drive(R, 3'b000, FUNC7_BASE, 32'd9, 32'd9);
    bus.ready_i = 1'b0;
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    @(negedge clk);
    chk("hold.result", bus.result_o, 32'd18);
    rst_n = 1'b0;
    #1;
    chk("hold_rst.valid", 32'(bus.valid_o), 32'd0);
    chk("hold_rst.result", bus.result_o, 32'd0);
    chk("hold_rst.ready", 32'(bus.ready_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.ready_i = 1'b1;
    #1;
    chk("hold_rel.ready", 32'(bus.ready_o), 32'd1);
    do_op("add_after_rst", R, 3'b000, FUNC7_BASE, 32'd1, 32'd1, 32'd2, 1'b0);

`ifdef ALU_MUL_EN
    do_mul("mulh",   3'b001, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF);
    do_mul("mulhu",  3'b011, 32'hFFFFFFFF, 32'd2, 32'h00000001);
    do_mul("mul",    3'b000, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE);
    do_mul("mulhsu", 3'b010, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF);
    do_mul("mulh_min", 3'b001, 32'h80000000, 32'h80000000, 32'h40000000);

    // Reset ten cycles into a multiply
    @(posedge clk); #1;
    drive(R, 3'b000, FUNC7_MULDIV, 32'd7, 32'd7);
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk("mulrst.busy_valid", 32'(bus.valid_o), 32'd0);
    chk("mulrst.busy_ready", 32'(bus.ready_o), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mulrst.valid", 32'(bus.valid_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mulrst.idle_ready", 32'(bus.ready_o), 32'd1);
    chk("mulrst.idle_valid", 32'(bus.valid_o), 32'd0);
    do_op("add_after_mulrst", R, 3'b000, FUNC7_BASE, 32'd1, 32'd1, 32'd2, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_mc.md
# alu_mc

Multi-cycle, parametrised successor to the execute-stage ALU. Decodes the full RV32I integer register-register and register-immediate ALU operations from opcode/func3/func7 and returns a registered result over a valid/ready handshake. Optionally adds an iterative RV32M multiplier (MUL/MULH/MULHSU/MULHU). Sits between decode/register-read and writeback, and back-pressures decode while a multiply is in flight.

## Interface
- REGISTER_SIZE, 32, operand/result width; must be a power of two ≥ 8.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset; asynchronous, active-low.
- valid_i  in  1  operation presented on data/opcode/func inputs.
- ready_o  out  1  block accepts the operation this cycle; transfer occurs when valid_i & ready_o.
- data1_i  in  REGISTER_SIZE  rs1 operand.
- data2_i  in  REGISTER_SIZE  rs2 operand or sign-extended immediate.
- opcode_i  in  7  instruction opcode.
- func3_i  in  3  instruction func3.
- func7_i  in  7  instruction func7; for I-type shifts, imm[11:5].
- valid_o  out  1  result_o and illegal_o hold a result.
- ready_i  in  1  consumer takes the result when valid_o & ready_i.
- result_o  out  REGISTER_SIZE  registered result.
- illegal_o  out  1  accepted operation was not decodable; result_o is 0.

## Operation
- The operands, opcode, func3 and func7 are captured only on an accepted transfer. The inputs are don't-care at all other times.
- Decode for opcode 0110011 (R-type) and 0010011 (I-type), by func3:
  - 000: ADD; SUB only when R-type and func7 = 0100000.
  - 001: SLL.
  - 010: SLT (signed).
  - 011: SLTU.
  - 100: XOR.
  - 101: SRL when func7 = 0000000; SRA when func7 = 0100000.
  - 110: OR.
  - 111: AND.
- Shift amount is data2_i[$clog2(REGISTER_SIZE)-1:0].
- SLT/SLTU produce 0 or 1, zero-extended to REGISTER_SIZE.
- I-type func3 000, 010, 011, 100, 110, 111 ignore func7.
- The following set illegal_o=1 and result_o=0 and complete with single-cycle latency:
  - any other opcode;
  - R-type func7 not allowed for its func3;
  - I-type shift with any other func7.
- All arithmetic is modulo 2^REGISTER_SIZE. There is no overflow flag.
- State machine (enum alu_state_e):
  - IDLE: no result held. ready_o=1.
    - Accepting a single-cycle op → DONE.
    - Accepting a multiply → MUL.
  - MUL: ready_o=0, valid_o=0. One shift-add step per cycle; counter runs REGISTER_SIZE−1 down to 0. At count 0 → DONE.
  - DONE: valid_o=1, ready_o=ready_i.
    - If ready_i & valid_i: accept the new op (single-cycle → stay DONE with the new result; multiply → MUL).
    - If ready_i & !valid_i: → IDLE.
    - If !ready_i: hold result_o and illegal_o stable.
- Single-cycle ops sustain one result per cycle under continuous valid_i/ready_i.
- Reset mid-operation: asynchronously abandons any multiply and returns to IDLE.
- Reset values: state=IDLE, valid_o=0, ready_o=1 after reset deasserts (0 while rst_ni=0), result_o=0, illegal_o=0, counter=0.

## Timing
- Single-cycle op accepted in cycle N → valid_o=1 in cycle N+1.
- Multiply accepted in cycle N → valid_o=1 in cycle N+REGISTER_SIZE+1 (N+33 at default width).
- ready_o depends combinationally on ready_i only in DONE. There is no other input-to-output combinational path.
- result_o and illegal_o are driven directly from flops.

## Configuration
- ALU_MUL_EN defined:
  - R-type func7 = 0000001 with func3 000/001/010/011 selects MUL/MULH/MULHSU/MULHU, routed through MUL state.
  - Signed operands are converted to magnitudes; the 2×REGISTER_SIZE product is negated at completion when the signs differ.
  - MUL returns the low half; the others return the high half.
  - func7 = 0000001 with func3 1xx is illegal.
- ALU_MUL_EN undefined:
  - func7 = 0000001 is illegal with single-cycle latency.
  - MUL state, counter and multiplier datapath are absent. The FSM has IDLE and DONE only.

## Structure
- Package alu_pkg holds:
  - OPCODE_OP = 7'b0110011, OPCODE_OP_IMM = 7'b0010011;
  - FUNC7_BASE, FUNC7_ALT, FUNC7_MULDIV;
  - typedef alu_op_e (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, MUL, MULH, MULHSU, MULHU, ILLEGAL);
  - typedef alu_state_e.
- Sub-module alu_mul_iter holds the iterative multiplier (compiled only under ALU_MUL_EN). It uses a start/done handshake, with operands and sign mode captured on start.

## Test plan
- Reset, then ADD R-type 5 + 7 → valid_o one cycle after accept, result_o=12, illegal_o=0.
- SUB R-type (func7 0100000) 3 − 5 → 0xFFFFFFFE. SLT −1 vs 1 → 1. SLTU same operands → 0.
- SRAI 0x80000000 by 4 (func7 0100000) → 0xF8000000. SRLI by 4 → 0x08000000. opcode 1111111 → illegal_o=1, result_o=0.
- Back-to-back ADDs for 8 cycles with ready_i=1 → 8 consecutive valid_o cycles. Drop ready_i for 3 cycles → result_o held, ready_o=0.
- With ALU_MUL_EN: MULH 0xFFFFFFFF × 0x00000002 → 0xFFFFFFFF after 33 cycles; MULHU same operands → 0x00000001; MUL same operands → 0xFFFFFFFE.
- Assert rst_ni low 10 cycles into a MUL → valid_o=0, state IDLE. Next ADD 1 + 1 → 2 with normal latency.
